// File: rtl/fifo_word_packer_if.sv
// Byte-FIFO read port and packed-word valid/ready stream of the word packer.
// The master side is the packer itself; the slave side is its environment
// (the byte FIFO and the word consumer).
interface fifo_word_packer_if #(
  parameter int BPW = 4
);
  logic [7:0]       fifo_dout;
  logic             fifo_empty;
  logic             fifo_rd;
  logic             word_ready;
  logic             word_valid;
  logic [8*BPW-1:0] word;

  modport master (
    input  fifo_dout, fifo_empty, word_ready,
    output fifo_rd, word_valid, word
  );

  modport slave (
    output fifo_dout, fifo_empty, word_ready,
    input  fifo_rd, word_valid, word
  );
endinterface

// File: rtl/fifo_word_packer.sv
// Pops bytes from a show-ahead byte FIFO and packs BPW of them into one word,
// presented on a valid/ready stream. Assembly of the next word runs while the
// finished word waits, so bytes flow at one per cycle unless the consumer
// stalls with a full word held and the last byte of the next one pending.
module fifo_word_packer #(
  parameter int BPW    = 4,   // bytes per word, 2..8
  parameter int ENDIAN = 0,   // 0: first byte in [7:0]; 1: first byte in top lane
  parameter int CW     = 16   // completed-word counter width
) (
  input  logic          clkb,
  input  logic          resetb,
  input  logic          flush,
  output logic [2:0]    byte_cnt,
  output logic [CW-1:0] word_count,
  fifo_word_packer_if.master bus
);

  typedef enum logic {
    ST_EMPTY = 1'b0,   // no word on the output
    ST_HOLD  = 1'b1    // a complete word is offered on the output
  } out_state_e;

  out_state_e           state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [BPW-1:0][7:0]  asm_q, asm_d, asm_merged;
  logic [8*BPW-1:0]     word_q, word_d;
  logic [CW-1:0]        wc_q, wc_d;
  logic [2:0]           lane;
  logic                 last;
  logic                 word_valid;
  logic                 pop;
  logic                 complete;
  logic                 handshake;

  assign word_valid = (state_q == ST_HOLD);
  assign last       = (cnt_q == 3'(BPW-1));
  assign lane       = (ENDIAN != 0) ? (3'(BPW-1) - cnt_q) : cnt_q;

  // NOTE: word_ready reaches fifo_rd combinationally on purpose: the last byte
  // of a word may only be popped when the held word leaves on the same edge.
  // Gating with resetb keeps the pop strobe low for the whole reset interval.
  assign pop       = resetb & ~bus.fifo_empty & ~flush &
                     (~last | ~word_valid | bus.word_ready);
  assign complete  = pop & last;
  assign handshake = word_valid & bus.word_ready;

  // Assembly buffer with the head byte dropped into its lane.
  always_comb begin
    asm_merged = asm_q;
    for (int i = 0; i < BPW; i++) begin
      if (lane == 3'(i)) asm_merged[i] = bus.fifo_dout;
    end
  end

  // Assembly side: byte counter and buffer, cleared by flush or completion.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    cnt_d = cnt_q;
    asm_d = asm_q;
    if (flush || complete) begin
      cnt_d = 3'd0;
      asm_d = '0;
    end else if (pop) begin
      cnt_d = cnt_q + 3'd1;
      asm_d = asm_merged;
    end
  end

  // Output controller: next state, output word and handshake counter.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    wc_d    = wc_q;
    if (handshake) wc_d = wc_q + CW'(1);
    if (complete)  word_d = asm_merged;
    case (state_q)
      ST_EMPTY: if (complete) state_d = ST_HOLD;
      ST_HOLD:  if (handshake && !complete) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // State registers; reset discards both the partial and the held word.
  always_ff @(posedge clkb or negedge resetb) begin
    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers see pre-edge values regardless of evaluation order.
    if (!resetb) begin
      state_q <= ST_EMPTY;
      cnt_q   <= 3'd0;
      asm_q   <= '0;
      word_q  <= '0;
      wc_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      word_q  <= word_d;
      wc_q    <= wc_d;
    end
  end

  assign bus.fifo_rd    = pop;
  assign bus.word_valid = word_valid;
  assign bus.word       = word_q;
  assign byte_cnt       = cnt_q;
  assign word_count     = wc_q;

endmodule
